// File: rtl/bq_coef_loader.sv
// bq_coef_loader: Wishbone master that writes five biquad coefficients to BASE_ADDR+0..4.
// Define BQLOAD_READBACK_EN to add a read-back pass that verifies every written coefficient.
module bq_coef_loader #(
    parameter int unsigned COEFWIDTH = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                     wb_clk_i,
    input  logic                     nreset,
    input  logic                     start_i,
    input  logic [5*COEFWIDTH-1:0]   coefs_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [1:0]               err_o,
    output logic [2:0]               err_idx_o,
    output logic                     wb_cyc_o,
    output logic                     wb_stb_o,
    output logic                     wb_we_o,
    output logic [31:0]              wb_adr_o,
    output logic [31:0]              wb_dat_o,
    input  logic [31:0]              wb_dat_i,
    input  logic                     wb_ack_i
);

    localparam int unsigned NCOEF = 5;
    localparam int unsigned IDXW  = 3;
    localparam int unsigned CNTW  = 16;
    localparam logic [IDXW-1:0] END_IDX  = IDXW'(NCOEF);
    localparam logic [1:0]      ERR_OK   = 2'd0;
    localparam logic [1:0]      ERR_TOUT = 2'd1;
`ifdef BQLOAD_READBACK_EN
    localparam logic [1:0]      ERR_MISM = 2'd2;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_GAP,
`ifdef BQLOAD_READBACK_EN
        S_RDREQ,
        S_RDGAP,
`endif
        S_FIN
    } state_t;

    state_t                      r_state;
    logic [5*COEFWIDTH-1:0]      r_coefs;
    logic [IDXW-1:0]             r_idx;
    logic [CNTW-1:0]             r_cnt;
    logic                        r_busy;
    logic                        r_done;
    logic [1:0]                  r_err;
    logic [2:0]                  r_err_idx;
    logic                        r_cyc;
    logic                        r_stb;
    logic                        r_we;
    logic [31:0]                 r_adr;
    logic [31:0]                 r_dat;

    logic [COEFWIDTH-1:0]        w_coef;
    logic                        w_tout;
    logic                        w_to_fin;
    logic                        w_unused_dat;
`ifdef BQLOAD_READBACK_EN
    logic                        w_mis;
`endif

    function automatic logic [31:0] sext32(input logic [COEFWIDTH-1:0] c);
        return 32'($signed(c));
    endfunction

    // Latched coefficient addressed by the current beat index.
    always_comb begin
        w_coef = r_coefs[0 +: COEFWIDTH];
        case (r_idx)
            3'd1:    w_coef = r_coefs[1*COEFWIDTH +: COEFWIDTH];
            3'd2:    w_coef = r_coefs[2*COEFWIDTH +: COEFWIDTH];
            3'd3:    w_coef = r_coefs[3*COEFWIDTH +: COEFWIDTH];
            3'd4:    w_coef = r_coefs[4*COEFWIDTH +: COEFWIDTH];
            default: w_coef = r_coefs[0 +: COEFWIDTH];
        endcase
    end

    assign w_tout       = (r_cnt == CNTW'(TIMEOUT - 1));
    assign w_unused_dat = ^wb_dat_i;
`ifdef BQLOAD_READBACK_EN
    assign w_mis        = (wb_dat_i[COEFWIDTH-1:0] != w_coef);
`endif

    // Sequence termination: timeout, final gap, or read-back mismatch.
    always_comb begin
        w_to_fin = 1'b0;
        case (r_state)
            S_REQ:   w_to_fin = !wb_ack_i && w_tout;
`ifdef BQLOAD_READBACK_EN
            S_GAP:   w_to_fin = 1'b0;
            S_RDREQ: w_to_fin = wb_ack_i ? w_mis : w_tout;
            S_RDGAP: w_to_fin = (r_idx == END_IDX);
`else
            S_GAP:   w_to_fin = (r_idx == END_IDX);
`endif
            default: w_to_fin = 1'b0;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge nreset) begin
        if (!nreset) begin
            r_state   <= S_IDLE;
            r_coefs   <= '0;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= ERR_OK;
            r_err_idx <= '0;
            r_cyc     <= 1'b0;
            r_stb     <= 1'b0;
            r_we      <= 1'b0;
            r_adr     <= '0;
            r_dat     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_coefs   <= coefs_i;
                        r_err     <= ERR_OK;
                        r_err_idx <= '0;
                        r_idx     <= '0;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_cyc     <= 1'b1;
                        r_stb     <= 1'b1;
                        r_we      <= 1'b1;
                        r_adr     <= BASE_ADDR;
                        r_dat     <= sext32(coefs_i[0 +: COEFWIDTH]);
                        r_state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (wb_ack_i) begin
                        r_stb   <= 1'b0;
                        r_cnt   <= '0;
                        r_idx   <= r_idx + IDXW'(1);
                        r_state <= S_GAP;
                    end else if (w_tout) begin
                        r_err     <= ERR_TOUT;
                        r_err_idx <= r_idx;
                    end else begin
                        r_cnt <= r_cnt + CNTW'(1);
                    end
                end
                S_GAP: begin
                    // Index already points at the next beat; acks here are ignored.
                    if (r_idx != END_IDX) begin
                        r_stb   <= 1'b1;
                        r_adr   <= BASE_ADDR + 32'(r_idx);
                        r_dat   <= sext32(w_coef);
                        r_state <= S_REQ;
                    end
`ifdef BQLOAD_READBACK_EN
                    else begin
                        r_stb   <= 1'b1;
                        r_we    <= 1'b0;
                        r_idx   <= '0;
                        r_adr   <= BASE_ADDR;
                        r_dat   <= '0;
                        r_state <= S_RDREQ;
                    end
`endif
                end
`ifdef BQLOAD_READBACK_EN
                S_RDREQ: begin
                    if (wb_ack_i) begin
                        if (w_mis) begin
                            r_err     <= ERR_MISM;
                            r_err_idx <= r_idx;
                        end else begin
                            r_stb   <= 1'b0;
                            r_cnt   <= '0;
                            r_idx   <= r_idx + IDXW'(1);
                            r_state <= S_RDGAP;
                        end
                    end else if (w_tout) begin
                        r_err     <= ERR_TOUT;
                        r_err_idx <= r_idx;
                    end else begin
                        r_cnt <= r_cnt + CNTW'(1);
                    end
                end
                S_RDGAP: begin
                    if (r_idx != END_IDX) begin
                        r_stb   <= 1'b1;
                        r_adr   <= BASE_ADDR + 32'(r_idx);
                        r_state <= S_RDREQ;
                    end
                end
`endif
                S_FIN:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase

            // Common exit path overrides the per-state bus outputs.
            if (w_to_fin) begin
                r_state <= S_FIN;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_cyc   <= 1'b0;
                r_stb   <= 1'b0;
                r_we    <= 1'b0;
                r_adr   <= '0;
                r_dat   <= '0;
                r_cnt   <= '0;
            end
        end
    end

    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign err_o     = r_err;
    assign err_idx_o = r_err_idx;
    assign wb_cyc_o  = r_cyc;
    assign wb_stb_o  = r_stb;
    assign wb_we_o   = r_we;
    assign wb_adr_o  = r_adr;
    assign wb_dat_o  = r_dat;

endmodule

// File: tb/tb_bq_coef_loader.sv
// Self-checking bench for bq_coef_loader: table of load sequences against a Wishbone slave
// model with a beat scoreboard, plus hand-written start-ignore and mid-transfer reset sequences.
module tb_bq_coef_loader;

    localparam int unsigned CW   = 16;
    localparam int unsigned TOUT = 8;
    localparam logic [31:0] BASE = 32'h0;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        start = 1'b0;
    logic [79:0] coefs = '0;
    logic        busy_o, done_o;
    logic [1:0]  err_o;
    logic [2:0]  err_idx_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;

    always #5 clk = ~clk;

    bq_coef_loader #(.COEFWIDTH(CW), .BASE_ADDR(BASE), .TIMEOUT(TOUT)) dut (
        .wb_clk_i(clk), .nreset(nreset), .start_i(start), .coefs_i(coefs),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_idx_o(err_idx_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
    );

    typedef struct {
        logic [79:0] coefs;
        int          waits;
        int          noack;
        int          badrd;
        logic [1:0]  exp_err;
        logic [2:0]  exp_idx;
    } vec_t;

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } beat_t;

    beat_t exp_q[$];
    vec_t  vecs[$];
    int    errors = 0;
    int    checks = 0;
    int    sl_waits = 0;
    int    sl_noack = -1;
    int    sl_badrd = -1;
    logic [31:0] mem [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] sext(input logic [79:0] c, input int i);
        logic [15:0] x;
        x = c[i*16 +: 16];
        return {{16{x[15]}}, x};
    endfunction

    function automatic int exp_done(input vec_t v);
        int per;
        per = v.waits + 2;
        if (v.noack >= 0) return 1 + v.noack * per + int'(TOUT);
`ifdef BQLOAD_READBACK_EN
        if (v.badrd >= 0) return 1 + 5 * per + v.badrd * per + v.waits + 1;
        return 1 + 10 * per;
`else
        return 1 + 5 * per;
`endif
    endfunction

    // Slave model: acks after sl_waits stall cycles, checks each completed beat on the scoreboard.
    initial begin
        beat_t got;
        beat_t e;
        int    wcnt;
        wcnt     = 0;
        wb_ack_i = 1'b0;
        wb_dat_i = '0;
        forever begin
            @(negedge clk);
            if (!nreset || !(wb_cyc_o && wb_stb_o)) begin
                wb_ack_i = 1'b0;
                wcnt     = 0;
            end else if (wb_we_o && int'(wb_adr_o - BASE) == sl_noack) begin
                wb_ack_i = 1'b0;
            end else if (wcnt < sl_waits) begin
                wb_ack_i = 1'b0;
                wcnt++;
            end else begin
                wb_ack_i = 1'b1;
                wcnt     = 0;
                got      = '{wb_we_o, wb_adr_o, wb_we_o ? wb_dat_o : 32'h0};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat: unexpected beat %0h with empty scoreboard", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL beat: got we/adr/dat %0h expected %0h", got, e);
                    end
                end
                if (wb_we_o) mem[wb_adr_o[2:0]] = wb_dat_o;
                else wb_dat_i = (int'(wb_adr_o[2:0]) == sl_badrd) ? 32'h0 : mem[wb_adr_o[2:0]];
            end
        end
    end

    task automatic run_vec(input vec_t v, input bit repulse, input string name);
        int t, done_at, cyc_hi, stb_na, ed;
        ed = exp_done(v);
        for (int i = 0; i < 5; i++)
            if (v.noack < 0 || i < v.noack) exp_q.push_back('{1'b1, BASE + 32'(i), sext(v.coefs, i)});
`ifdef BQLOAD_READBACK_EN
        if (v.noack < 0)
            for (int i = 0; i < 5; i++)
                if (v.badrd < 0 || i <= v.badrd) exp_q.push_back('{1'b0, BASE + 32'(i), 32'h0});
`endif
        sl_waits = v.waits;
        sl_noack = v.noack;
        sl_badrd = v.badrd;
        @(negedge clk);
        coefs = v.coefs;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({name, "_c1"}, {56'h0, busy_o, wb_cyc_o, wb_stb_o, wb_we_o, err_o, err_idx_o[1:0]},
            {56'h0, 8'b1111_0000});
        chk({name, "_adr0"}, {32'h0, wb_adr_o}, {32'h0, BASE});
        t = 1; done_at = -1; cyc_hi = 0; stb_na = 0;
        while (t < 400) begin
            if (done_o) begin
                done_at = t;
                break;
            end
            if (wb_cyc_o) cyc_hi++;
            if (v.noack >= 0 && wb_stb_o && wb_adr_o == BASE + 32'(v.noack)) stb_na++;
            if (repulse && t == 4) begin
                start = 1'b1;
                coefs = ~v.coefs;
            end
            if (repulse && t == 5) start = 1'b0;
            @(negedge clk);
            t++;
        end
        chk({name, "_done_cycle"}, 64'(done_at), 64'(ed));
        chk({name, "_err"}, {61'h0, err_o, 1'b0} | {61'h0, err_idx_o}, {61'h0, v.exp_err, 1'b0} | {61'h0, v.exp_idx});
        chk({name, "_err_idx"}, 64'(err_idx_o), 64'(v.exp_idx));
        chk({name, "_fin_bus"}, {61'h0, wb_cyc_o, wb_stb_o, busy_o}, 64'h0);
        chk({name, "_cyc_cont"}, 64'(cyc_hi), 64'(ed - 1));
        if (v.noack >= 0) chk({name, "_stb_tout"}, 64'(stb_na), 64'(TOUT));
        chk({name, "_sb_empty"}, 64'(exp_q.size()), 64'h0);
        @(negedge clk);
        chk({name, "_done_pulse"}, {63'h0, done_o}, 64'h0);
        repeat (3) @(negedge clk);
        chk({name, "_idle"}, {62'h0, wb_cyc_o, busy_o}, 64'h0);
        exp_q.delete();
    endtask

    initial begin
        vec_t v;
        int   found;
        int   saw_done;
        logic [79:0] tp;
        tp = {16'h8000, 16'h0001, 16'h2000, 16'hC000, 16'h4001};

        vecs.push_back('{coefs: tp, waits: 0, noack: -1, badrd: -1, exp_err: 2'd0, exp_idx: 3'd0});
        vecs.push_back('{coefs: tp, waits: 3, noack: -1, badrd: -1, exp_err: 2'd0, exp_idx: 3'd0});
        vecs.push_back('{coefs: tp, waits: 0, noack: 2,  badrd: -1, exp_err: 2'd1, exp_idx: 3'd2});
        vecs.push_back('{coefs: {16'h7FFF, 16'hFFFF, 16'h0000, 16'h1234, 16'h8001},
                         waits: 1, noack: 0, badrd: -1, exp_err: 2'd1, exp_idx: 3'd0});
        vecs.push_back('{coefs: tp, waits: 2, noack: 4,  badrd: -1, exp_err: 2'd1, exp_idx: 3'd4});
        vecs.push_back('{coefs: 80'({$urandom(), $urandom(), $urandom()}),
                         waits: 1, noack: -1, badrd: -1, exp_err: 2'd0, exp_idx: 3'd0});
`ifdef BQLOAD_READBACK_EN
        vecs.push_back('{coefs: tp, waits: 0, noack: -1, badrd: 2, exp_err: 2'd2, exp_idx: 3'd2});
`endif

        repeat (2) @(negedge clk);
        chk("reset_outputs", {busy_o, done_o, err_o, err_idx_o, wb_cyc_o, wb_stb_o, wb_we_o,
                              wb_adr_o[15:0], wb_dat_o[31:0]}, 64'h0);
        nreset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], 1'b0, $sformatf("vec%0d", i));

        // Second start during a busy sequence with different coefficients must be dropped.
        run_vec(vecs[0], 1'b1, "repulse");

        // Reset during beat 3: bus drops at once, no done pulse.
        for (int i = 0; i < 3; i++) exp_q.push_back('{1'b1, BASE + 32'(i), sext(tp, i)});
        sl_waits = 2; sl_noack = -1; sl_badrd = -1;
        @(negedge clk);
        coefs = tp;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int k = 0; k < 100; k++) begin
            if (wb_stb_o && wb_adr_o == BASE + 32'd3) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        chk("rst_reach_beat3", 64'(found), 64'd1);
        #2 nreset = 1'b0;
        #1 chk("rst_async_drop", {60'h0, wb_cyc_o, wb_stb_o, busy_o, done_o}, 64'h0);
        chk("rst_beats_done", 64'(exp_q.size()), 64'h0);
        saw_done = 0;
        repeat (4) begin
            @(negedge clk);
            if (done_o) saw_done = 1;
        end
        chk("rst_no_done", 64'(saw_done), 64'h0);
        exp_q.delete();
        nreset = 1'b1;
        v = vecs[0];
        run_vec(v, 1'b0, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
